// File: rtl/ddr_rbuf_ctl.sv
// Circular-buffer controller for the DDR read-return 1K x 36 dual-port RAM, with a 2-entry
// prefetch queue on the output side. Optional byte parity via DDR_RBUF_PARITY_EN.
module ddr_rbuf_ctl #(
    parameter int unsigned AW        = 10,
    parameter int unsigned AFULL_LVL = 1008
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [35:0]   in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [35:0]   out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   level,
    output logic          afull,
    output logic          par_err,
    output logic [35:0]   bram_wd,
    output logic [AW-1:0] bram_aa,
    output logic          bram_ena,
    output logic          bram_wea,
    output logic [AW-1:0] bram_ab,
    output logic          bram_enb,
    input  logic [35:0]   bram_rdb
);

    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          inflight_q;
    logic [1:0]    qcnt_q, qcnt_d;
    logic [35:0]   q0_q, q0_d, q1_q, q1_d;
    logic          rdy_q;
    logic          push, pop, rd_iss;
    logic [1:0]    slots_used;

`ifdef DDR_RBUF_PARITY_EN
    function automatic logic [3:0] byte_par(input logic [31:0] d);
        return {^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
    endfunction
`endif

    assign in_ready  = rdy_q & ~flush;
    assign push      = in_valid & in_ready;
    assign out_valid = (qcnt_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_data  = q0_q;

    // A pop this cycle frees a queue slot for a read issued in the same cycle.
    assign slots_used = qcnt_q + {1'b0, inflight_q} - {1'b0, pop};
    assign rd_iss     = (cnt_q != '0) && (slots_used < 2'd2) && !flush;

    assign bram_ena = push;
    assign bram_wea = push;
    assign bram_aa  = wptr_q;
    assign bram_ab  = rptr_q;
    assign bram_enb = rd_iss;
`ifdef DDR_RBUF_PARITY_EN
    assign bram_wd  = {byte_par(in_data[31:0]), in_data[31:0]};
`else
    assign bram_wd  = in_data;
`endif

    assign level = cnt_q + {{AW{1'b0}}, inflight_q} + {{(AW-1){1'b0}}, qcnt_q};
    assign afull = (level >= (AW+1)'(AFULL_LVL));

    always_comb begin
        cnt_d = cnt_q;
        if (push && !rd_iss) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (rd_iss && !push) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    // Pop first, then append returning read data at the new tail.
    always_comb begin
        q0_d   = q0_q;
        q1_d   = q1_q;
        qcnt_d = qcnt_q;
        if (pop) begin
            q0_d   = q1_q;
            qcnt_d = qcnt_q - 2'd1;
        end
        if (inflight_q) begin
            if (qcnt_d == 2'd0) begin
                q0_d = bram_rdb;
            end else begin
                q1_d = bram_rdb;
            end
            qcnt_d = qcnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            qcnt_q     <= 2'd0;
            q0_q       <= '0;
            q1_q       <= '0;
            rdy_q      <= 1'b0;
        end else if (flush) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            qcnt_q     <= 2'd0;
            rdy_q      <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (rd_iss) begin
                rptr_q <= rptr_q + AW'(1);
            end
            cnt_q      <= cnt_d;
            inflight_q <= rd_iss;
            qcnt_q     <= qcnt_d;
            q0_q       <= q0_d;
            q1_q       <= q1_d;
            rdy_q      <= !cnt_d[AW];
        end
    end

`ifdef DDR_RBUF_PARITY_EN
    logic par_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else if (flush) begin
            par_err_q <= 1'b0;
        end else if (inflight_q && (byte_par(bram_rdb[31:0]) != bram_rdb[35:32])) begin
            par_err_q <= 1'b1;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_rbuf_ctl.sv
// Bench for ddr_rbuf_ctl: RAM model, word-queue reference model checked every cycle,
// plus directed literal checks for latency, full, streaming, flush and parity.
module tb_ddr_rbuf_ctl;
    localparam int unsigned AW        = 10;
    localparam int unsigned AFULL_LVL = 1008;
    localparam int unsigned DEPTH     = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush = 1'b0;
    logic [35:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [35:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW:0]   level;
    logic          afull;
    logic          par_err;
    logic [35:0]   bram_wd;
    logic [AW-1:0] bram_aa;
    logic          bram_ena;
    logic          bram_wea;
    logic [AW-1:0] bram_ab;
    logic          bram_enb;
    logic [35:0]   bram_rdb = '0;

    ddr_rbuf_ctl #(.AW(AW), .AFULL_LVL(AFULL_LVL)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .afull(afull), .par_err(par_err),
        .bram_wd(bram_wd), .bram_aa(bram_aa), .bram_ena(bram_ena), .bram_wea(bram_wea),
        .bram_ab(bram_ab), .bram_enb(bram_enb), .bram_rdb(bram_rdb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) begin
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
            end
        end
    endfunction

    function automatic logic [35:0] exp_word(input logic [35:0] d);
`ifdef DDR_RBUF_PARITY_EN
        logic [3:0] p;
        for (int b = 0; b < 4; b++) begin
            p[b] = ($countones(d[8*b +: 8]) % 2) == 1;
        end
        return {p, d[31:0]};
`else
        return d;
`endif
    endfunction

    function automatic logic [35:0] rnd36();
        logic [35:0] r;
        r = {4'($urandom), 32'($urandom)};
        return r;
    endfunction

    // Synchronous-read RAM, no output register; optionally corrupts bit 32 of one write.
    logic [35:0] mem [DEPTH];
    bit corrupt_now = 1'b0;
    bit inject_req  = 1'b0;

    always @(posedge clk) begin
        if (bram_ena && bram_wea) begin
            mem[bram_aa] <= bram_wd ^ (corrupt_now ? 36'h1_0000_0000 : 36'h0);
        end
        if (bram_enb) begin
            bram_rdb <= mem[bram_ab];
        end
    end

    // Reference model: ordered list of words held, each stamped with its accept edge.
    typedef struct {
        logic [35:0] d;
        int unsigned t;
        bit          bad;
    } ent_t;

    ent_t        mq[$];
    int unsigned ecnt = 0;
    int unsigned since_rst = 0;
    int unsigned waddr = 0;
    int          par_st = 0;   // 0: must be clear, 1: must be set, 2: undetermined
    bit          prev_flush = 1'b0;

    always @(posedge clk) begin
        ecnt <= ecnt + 1;
        since_rst <= rst_n ? since_rst + 1 : 0;
    end

    always @(negedge clk) begin
        bit push, pop, ov_exp;
        logic [35:0] hd;
        if (!rst_n) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_afull", afull, 0);
            check("rst_par_err", par_err, 0);
            check("rst_ena", bram_ena, 0);
            check("rst_enb", bram_enb, 0);
            check("rst_level", level, 0);
            mq.delete();
            waddr = 0;
            par_st = 0;
            prev_flush = 1'b0;
            inject_req = 1'b0;
            corrupt_now = 1'b0;
        end else begin
            push = in_valid && in_ready;
            pop  = out_valid && out_ready;
            // A word is visible at the output from the second edge after it was accepted.
            ov_exp = (mq.size() > 0) && (mq[0].t + 2 <= ecnt);
            check("out_valid", out_valid, ov_exp);
            if (ov_exp) begin
                hd = exp_word(mq[0].d) ^ (mq[0].bad ? 36'h1_0000_0000 : 36'h0);
                check("out_data", out_data, hd);
            end
            check("level", level, mq.size());
            check("afull", afull, mq.size() >= AFULL_LVL);
            check("bram_ena", bram_ena, push);
            check("bram_wea", bram_wea, push);
            if (push) begin
                check("bram_aa", bram_aa, waddr);
                check("bram_wd", bram_wd, exp_word(in_data));
            end
            if (bram_ena && bram_wea && bram_enb) begin
                check("addr_collision", bram_aa == bram_ab, 0);
            end
            if (mq.size() == 0) begin
                check("enb_when_empty", bram_enb, 0);
            end
            if (flush) begin
                check("in_ready_flush", in_ready, 0);
            end else if (since_rst >= 1 && !prev_flush) begin
                if (mq.size() < DEPTH) check("in_ready_room", in_ready, 1);
                if (mq.size() >= DEPTH + 2) check("in_ready_full", in_ready, 0);
            end
`ifdef DDR_RBUF_PARITY_EN
            if (ov_exp && mq[0].bad) par_st = 1;
            if (par_st == 0) check("par_err_clear", par_err, 0);
            if (par_st == 1) check("par_err_set", par_err, 1);
`else
            check("par_err_tied", par_err, 0);
`endif
            if (pop && mq.size() > 0) void'(mq.pop_front());
            corrupt_now = inject_req && push;
            if (corrupt_now) inject_req = 1'b0;
            if (push) begin
                mq.push_back('{d: in_data, t: ecnt + 1, bad: corrupt_now});
                waddr = (waddr + 1) % DEPTH;
                if (corrupt_now) par_st = 2;
            end
            if (flush) begin
                mq.delete();
                waddr = 0;
                par_st = 0;
            end
            prev_flush = flush;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check(name, in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int n;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Single word latency.
        out_ready = 1'b1;
        wait_ready("t1_ready");
        in_valid = 1'b1;
        in_data  = 36'h0_DEADBEEF;
        tick();
        in_valid = 1'b0;
        tick();
        check("t1_not_yet_valid", out_valid, 0);
        tick();
        check("t1_valid_after_e2", out_valid, 1);
`ifdef DDR_RBUF_PARITY_EN
        check("t1_data", out_data, 36'h5_DEADBEEF);
`else
        check("t1_data", out_data, 36'h0_DEADBEEF);
`endif
        repeat (3) tick();
        check("t1_level_zero", level, 0);

        // Fill until full with the consumer stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        for (int i = 0; i < 1100; i++) begin
            in_data = rnd36();
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("fill_accepted", acc, 1026);
        check("fill_level", level, 1026);
        check("fill_afull", afull, 1);
        check("fill_in_ready", in_ready, 0);
        out_ready = 1'b1;
        repeat (1100) tick();
        check("drain_level", level, 0);

        // Continuous streaming across two pointer wraps.
        in_valid = 1'b1;
        acc = 0;
        n = 0;
        while (acc < 3000 && n < 3500) begin
            in_data = rnd36();
            if (in_ready) acc++;
            if (acc == 1500) check("stream_steady_level", level, 3);
            tick();
            n++;
        end
        check("stream_count", acc, 3000);
        in_valid = 1'b0;
        repeat (10) tick();
        check("stream_level_end", level, 0);

        // Random handshakes.
        acc = 0;
        n = 0;
        while (acc < 5000 && n < 30000) begin
            in_valid  = $urandom_range(1, 0) == 1;
            out_ready = $urandom_range(1, 0) == 1;
            in_data   = rnd36();
            if (in_valid && in_ready) acc++;
            tick();
            n++;
        end
        check("random_count", acc, 5000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (1100) tick();
        check("random_level_end", level, 0);

        // Flush with 500 buffered and a read in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        n = 0;
        while (acc < 500 && n < 600) begin
            in_data = rnd36();
            if (in_ready) acc++;
            tick();
            n++;
        end
        in_valid = 1'b0;
        repeat (2) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 36'h0_BAD0BAD0;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_level", level, 0);
        check("flush_out_valid", out_valid, 0);
        wait_ready("flush_ready_back");
        in_valid = 1'b1;
        in_data  = 36'h1_00000001;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check("post_flush_valid", out_valid, 1);
        check("post_flush_data", out_data, 36'h1_00000001);
        repeat (5) tick();

`ifdef DDR_RBUF_PARITY_EN
        // One corrupted word sets the sticky error; flush clears it.
        for (int i = 0; i < 6; i++) begin
            wait_ready("par_ready");
            if (i == 2) inject_req = 1'b1;
            in_valid = 1'b1;
            in_data  = rnd36();
            tick();
            in_valid = 1'b0;
        end
        repeat (10) tick();
        check("par_err_after", par_err, 1);
        repeat (5) tick();
        check("par_err_sticky", par_err, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("par_err_flushed", par_err, 0);
        repeat (3) tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
